// File: rtl/uart_pkg.sv
// Shared types and constants for the SPART-style UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam logic        LINE_IDLE  = 1'b1;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit serializer: loads a byte on t_enable, shifts it out LSB-first
// one bit per baud_enable tick, and reports buffer-ready on tbr.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_enable,
    input  logic              t_enable,
    input  logic [DATA_W-1:0] data,
    output logic              txd,
    output logic              tbr
);

    localparam int unsigned        CntW    = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0]    CntLast = CntW'(DATA_W);

    tx_state_t         r_state;
    tx_state_t         w_state_d;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic              r_txd;
    logic              w_txd_d;
    logic              r_tbr;
    logic              w_tbr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_txd   <= LINE_IDLE;
            r_tbr   <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_txd   <= w_txd_d;
            r_tbr   <= w_tbr_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_txd_d   = r_txd;
        w_tbr_d   = r_tbr;
        unique case (r_state)
            // A baud tick coinciding with the load is deliberately not the start tick.
            IDLE: begin
                w_txd_d = LINE_IDLE;
                if (t_enable) begin
                    w_shift_d = data;
                    w_tbr_d   = 1'b0;
                    w_state_d = LOADED;
                end
            end
            LOADED: begin
                if (baud_enable) begin
                    w_txd_d   = START_BIT;
                    w_cnt_d   = '0;
                    w_state_d = START;
                end
            end
            START: begin
                if (baud_enable) begin
                    w_txd_d   = r_shift[0];
                    w_shift_d = r_shift >> 1;
                    w_cnt_d   = CntW'(1);
                    w_state_d = DATA;
                end
            end
            DATA: begin
                if (baud_enable) begin
                    if (r_cnt < CntLast) begin
                        w_txd_d   = r_shift[0];
                        w_shift_d = r_shift >> 1;
                        w_cnt_d   = r_cnt + CntW'(1);
                    end else begin
                        w_txd_d   = STOP_BIT;
                        w_state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_enable) begin
                    w_txd_d   = LINE_IDLE;
                    w_tbr_d   = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_txd_d   = LINE_IDLE;
                w_tbr_d   = 1'b1;
                w_state_d = IDLE;
            end
        endcase
    end

    assign txd = r_txd;
    assign tbr = r_tbr;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected line bits are queued at each
// load and popped as baud ticks shift them out.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic       baud_enable;
    logic       t_enable;
    logic [7:0] data;
    logic       txd;
    logic       tbr;

    int   n_cmp;
    int   n_err;
    logic q_exp[$];

    uart_tx_serializer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_enable(baud_enable),
        .t_enable   (t_enable),
        .data       (data),
        .txd        (txd),
        .tbr        (tbr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    // Latch a byte and queue its frame: start, d0..d7, stop.
    task automatic load(input logic [7:0] d, input logic with_baud);
        t_enable    = 1'b1;
        baud_enable = with_baud;
        data        = d;
        @(posedge clk);
        #1;
        t_enable    = 1'b0;
        baud_enable = 1'b0;
        data        = 8'($urandom);
        chk("load_tbr", tbr, 1'b0);
        chk("load_txd", txd, 1'b1);
        q_exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) q_exp.push_back(d[i]);
        q_exp.push_back(1'b1);
    endtask

    // One-cycle baud pulse, outputs sampled 1 ns after the edge, then spacing.
    task automatic pulse(input logic also_load);
        baud_enable = 1'b1;
        t_enable    = also_load;
        data        = 8'($urandom);
        @(posedge clk);
        #1;
        baud_enable = 1'b0;
        t_enable    = 1'b0;
    endtask

    task automatic space();
        repeat (11) @(posedge clk);
        #1;
    endtask

    task automatic tick_bit(input string tag);
        logic e;
        pulse(1'b0);
        if (q_exp.size() == 0) begin
            chk({tag, "_underflow"}, 1'b1, 1'b0);
        end else begin
            e = q_exp.pop_front();
            chk({tag, "_txd"}, txd, e);
        end
        chk({tag, "_tbr"}, tbr, 1'b0);
        space();
    endtask

    task automatic tick_end(input string tag, input logic also_load);
        pulse(also_load);
        chk({tag, "_end_tbr"}, tbr, 1'b1);
        chk({tag, "_end_txd"}, txd, 1'b1);
    endtask

    task automatic frame(input string tag, input logic [7:0] d);
        load(d, 1'b0);
        for (int i = 0; i < 10; i++) tick_bit(tag);
        tick_end(tag, 1'b0);
        space();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        baud_enable = 1'b0;
        t_enable    = 1'b0;
        data        = 8'h00;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            baud_enable = 1'($urandom);
            t_enable    = 1'($urandom);
            data        = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_txd", txd, 1'b1);
            chk("rst_tbr", tbr, 1'b1);
        end
        baud_enable = 1'b0;
        t_enable    = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_txd", txd, 1'b1);
        chk("post_rst_tbr", tbr, 1'b1);

        frame("fe", 8'hFE);

        // Busy load mid-frame must be ignored.
        load(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) tick_bit("a5");
        t_enable = 1'b1;
        data     = 8'h00;
        @(posedge clk);
        #1;
        t_enable = 1'b0;
        chk("busy_tbr", tbr, 1'b0);
        for (int i = 0; i < 6; i++) tick_bit("a5");
        tick_end("a5", 1'b0);
        space();

        // Idle ticks do nothing.
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0);
            chk("idle_txd", txd, 1'b1);
            chk("idle_tbr", tbr, 1'b1);
            space();
        end
        frame("01", 8'h01);

        // Load and baud together: tick not counted as start.
        load(8'h96, 1'b1);
        chk("sim_txd", txd, 1'b1);
        for (int i = 0; i < 10; i++) tick_bit("96");
        // Load on the STOP->IDLE edge is ignored.
        tick_end("96", 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("stop_edge_tbr", tbr, 1'b1);
        chk("stop_edge_txd", txd, 1'b1);
        space();

        // Reset mid-frame.
        load(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) tick_bit("c3");
        rst = 1'b0;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_tbr", tbr, 1'b1);
        q_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame("3c", 8'h3C);

        // Back-to-back frames.
        load(8'hE7, 1'b0);
        for (int i = 0; i < 10; i++) tick_bit("e7");
        tick_end("e7", 1'b0);
        load(8'h55, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_gap_txd", txd, 1'b1);
        for (int i = 0; i < 10; i++) tick_bit("55");
        tick_end("55", 1'b0);
        chk("queue_empty", q_exp.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide UART transmit serializer for the SPART-style serial port.
- Accepts a parallel byte from the bus interface on a one-cycle load strobe.
- Shifts the byte out LSB-first, framed as 8N1: 1 start bit (0), 8 data bits, 1 stop bit (1).
- Advances one bit per baud tick from the shared baud-rate generator; reports buffer-ready status back to the bus side.

Parameters:
- DATA_W, 8, number of data bits per frame. Only 8 is required to be supported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- baud_enable  input  1  one-clk-wide pulse, once per bit period.
- t_enable  input  1  one-clk-wide load strobe from the bus interface.
- data  input  DATA_W  byte to transmit; sampled only on an accepted load.
- txd  output  1  serial line, idle high; driven from a register (glitch-free).
- tbr  output  1  transmit buffer ready; 1 = idle, a new byte may be loaded.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, txd=1, tbr=1, shift register and bit counter cleared.
  - Takes effect immediately, including mid-frame; an aborted frame is not resumed.
- IDLE (txd=1, tbr=1):
  - t_enable=1 latches data into the shift register, next state LOADED, tbr=0 on the following cycle.
  - baud_enable alone has no effect.
- LOADED (txd=1, tbr=0):
  - Waits for a baud_enable.
  - On baud_enable: txd=0 (start bit), counter=0, go to START.
- START:
  - On baud_enable: txd=shift[0], shift right, counter=1, go to DATA.
- DATA:
  - On each baud_enable with counter<DATA_W: txd=shift[0], shift right, counter+1.
  - On baud_enable with counter==DATA_W: txd=1 (stop bit), go to STOP.
- STOP:
  - On baud_enable: tbr=1, txd stays 1, go to IDLE.
- Frame timing:
  - The load is followed by exactly DATA_W+3 baud ticks until tbr returns to 1.
  - Tick 1 = start bit; ticks 2..9 = d0..d7; tick 10 = stop bit; tick 11 = tbr=1.
  - Each bit holds the line for one full baud period.
- Output timing: txd and tbr update on the clk edge at which baud_enable (or t_enable) is sampled high. There is no combinational path from any input to txd or tbr.
- t_enable while tbr=0 is ignored: no reload, frame not disturbed.
- data changes after the load do not affect the frame in flight.
- If t_enable and baud_enable are both high in IDLE: the load is accepted, and the baud tick is not counted as the start tick.
- If t_enable arrives on the same edge tbr returns to 1 (STOP→IDLE edge): ignored, because tbr was 0 when sampled.
- If baud_enable is held high for multiple cycles, each high cycle counts as a tick. The generator must pulse for one cycle only.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum: IDLE, LOADED, START, DATA, STOP.
  - Constants: DATA_W_DEF=8, LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- No sub-module needed.
- Single module with a state register, shift register and bit counter of width $clog2(DATA_W+1).

Test Plan:
- Reset: hold rst=0 for 5 clk with random inputs -> txd=1, tbr=1 throughout. Deassert -> both remain 1 with no load.
- Basic frame: data=8'hFE, t_enable pulse, then 11 baud pulses spaced 12 clk apart -> tbr=0 after the load, with txd sampled after each tick:
  - Ticks 1..10: 0 (start), 0, 1, 1, 1, 1, 1, 1, 1, 1 (stop).
  - Tick 11: tbr=1.
  - Tbr stays 0 until tick 11.
- Busy load ignored: mid-frame (after tick 4) pulse t_enable with data=8'h00 -> frame for 8'hA5 completes unchanged: d0..d7 = 1,0,1,0,0,1,0,1.
- Idle ticks: 5 baud pulses with no load -> txd=1, tbr=1 unchanged. Then load 8'h01 -> start bit appears only on the first subsequent tick.
- Reset mid-frame: assert rst=0 after tick 5 -> txd=1, tbr=1 within the same time step. Next frame 8'h3C transmits correctly.
- Back-to-back: load 8'h55 on the cycle after tbr rises, 11 more ticks -> second frame is correct; line stays 1 between the stop bit and the next start bit.
